sargantana_itag_store: RTL
==========================

SARGANTANA_ITAG_STORE -- requirements
Module: sargantana_itag_store

Interface
REQ-001 The block SHALL have parameter N_WAY, default ICACHE_N_WAY (4), meaning the number of ways.
REQ-002 The block SHALL have parameter DEPTH, default ICACHE_DEPTH (64), meaning the number of sets; it is a power of two, at least 2.
REQ-003 The block SHALL have parameter TAG_W, default TAG_WIDHT, meaning the tag width in bits.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_i, input, N_WAY bits: per-way request.
REQ-007 The block SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port vbit_i, input, 1 bit: valid value to write.
REQ-009 The block SHALL have port data_i, input, TAG_W bits: tag to write.
REQ-010 The block SHALL have port addr_i, input, clog2(DEPTH) bits: set index.
REQ-011 The block SHALL have port cmp_tag_i, input, TAG_W bits: lookup tag, sampled with a read.
REQ-012 The block SHALL have port flush_i, input, 1 bit: a one-cycle pulse that starts invalidation.
REQ-013 The block SHALL have port ready_o, output, 1 bit: requests are accepted.
REQ-014 The block SHALL have port tag_way_o, output, N_WAY x TAG_W bits: read tags.
REQ-015 The block SHALL have port vbit_o, output, N_WAY bits: read valid bits.
REQ-016 The block SHALL have port rvalid_o, output, 1 bit: read data valid this cycle.
REQ-017 The block SHALL have port hit_way_o, output, N_WAY bits: one-hot way hit.
REQ-018 The block SHALL have port hit_o, output, 1 bit: OR of hit_way_o.

Function
REQ-019 A request SHALL be accepted only when ready_o=1 and |req_i=1; other requests are dropped silently.
REQ-020 An accepted write SHALL update the tag and valid bit of every way with req_i[w]=1 at addr_i on the same edge; unrequested ways are unchanged.
REQ-021 An accepted read SHALL produce results one cycle later, with rvalid_o=1 for exactly one cycle.
REQ-022 On that result cycle, requested ways SHALL drive tag_way_o[w]=stored tag and vbit_o[w]=stored valid.
REQ-023 On that result cycle, unrequested ways SHALL drive vbit_o[w]=0 and tag_way_o[w] holding its previous value.
REQ-024 On that result cycle, hit_way_o[w] SHALL equal vbit_o[w] AND (stored tag == cmp_tag_i); if more than one way hits, all hitting bits are set and no priority is applied.
REQ-025 A read in the cycle after a write to the same set SHALL return the newly written data.
REQ-026 rvalid_o, vbit_o and hit_way_o SHALL be 0 in every cycle not following an accepted read; tag_way_o SHALL hold.
REQ-027 The FSM SHALL have two states, IDLE and SWEEP, with a set counter cnt of clog2(DEPTH) bits.
REQ-028 In IDLE, ready_o SHALL be 1; flush_i=1 SHALL cause IDLE->SWEEP with cnt=0, and any request in that same cycle is dropped.
REQ-029 In SWEEP, ready_o SHALL be 0; each cycle the valid bits of all ways at set cnt are cleared and cnt increments; when cnt=DEPTH-1 the FSM returns to IDLE and cnt wraps to 0.
REQ-030 SWEEP SHALL therefore last exactly DEPTH cycles; flush_i during SWEEP is ignored and does not restart the sweep.
REQ-031 Tags SHALL never be cleared by a flush or a sweep.

Reset
REQ-032 While rstn_i=0, all outputs SHALL be 0, including ready_o.
REQ-033 On rstn_i release, the FSM SHALL enter SWEEP with cnt=0 so that all valid bits are cleared before the first accepted request.
REQ-034 The tag and valid arrays SHALL have no reset; they are SRAM-like storage and are initialised only by the sweep.
REQ-035 Reset asserted mid-sweep SHALL abort the sweep immediately; the sweep restarts from set 0 after release.

Structure
REQ-036 The package sargantana_icache_pkg SHALL hold the default constants and the typedef itag_store_state_t {IDLE, SWEEP}.
REQ-037 The block SHALL use one sub-module, sargantana_itag_way_array, instantiated N_WAY times, each holding one way's tag and valid storage with a registered read.
REQ-038 The FSM, compare logic and output muxing SHALL be in the top level.

Verification (N_WAY=4, DEPTH=64, TAG_W=20)
REQ-039 Release reset -> ready_o=0 for exactly 64 cycles, then 1; a read of set 17 on all ways returns vbit_o=4'b0000 and hit_o=0.
REQ-040 Write req=4'b0100, addr 5, tag 20'hABCDE, vbit 1; next cycle read req=4'hF, addr 5, cmp 20'hABCDE -> one cycle later rvalid_o=1, vbit_o=4'b0100, tag_way_o[2]=20'hABCDE, hit_way_o=4'b0100.
REQ-041 Pulse flush_i with a write request in the same cycle -> write dropped; ready_o=0 for 64 cycles; a later read of addr 5 gives vbit_o=0 with tag_way_o[2] still 20'hABCDE; flush_i at sweep cycle 10 does not extend the sweep.
REQ-042 Assert rstn_i at sweep cnt=30 -> outputs 0 immediately; after release, ready_o=0 for a full 64 cycles.
REQ-043 Read with req=4'b0001 -> vbit_o[3:1]=0 and tag_way_o[3:1] unchanged; a write with req=4'b0000 has no effect on any way; two ways written with the same tag both hit -> hit_way_o shows both bits.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared constants and types for the Sargantana instruction-cache tag store.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY = 4;
  localparam int ICACHE_DEPTH = 64;
  localparam int TAG_WIDHT    = 20;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } itag_store_state_t;

endpackage

// File: rtl/sargantana_itag_way_array.sv
// One way of the tag store: SRAM-like tag/valid storage with a registered read port.
// Storage has no reset; valid bits are cleared one set at a time by the sweep port.
module sargantana_itag_way_array #(
  parameter int DEPTH  = 64,
  parameter int TAG_W  = 20,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [TAG_W-1:0]  data_i,
  input  logic              vbit_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic              vbit_o
);

  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic             vbit_mem [DEPTH];

  logic [TAG_W-1:0] tag_d, tag_q;
  logic             vbit_d, vbit_q;

  // Storage update: writes and sweep clears never coincide since writes are only accepted when idle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_mem[addr_i]  <= data_i;
      vbit_mem[addr_i] <= vbit_i;
    end
    if (clr_i) begin
      vbit_mem[clr_addr_i] <= 1'b0;
    end
  end

  // Read data register: captures the addressed entry on a read and holds otherwise.
  always_comb begin
    tag_d  = tag_q;
    vbit_d = vbit_q;
    if (re_i) begin
      tag_d  = tag_mem[addr_i];
      vbit_d = vbit_mem[addr_i];
    end
  end

  // Read register flops; reset so the outputs are quiet while the block is in reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tag_q  <= '0;
      vbit_q <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      vbit_q <= vbit_d;
    end
  end

  assign tag_o  = tag_q;
  assign vbit_o = vbit_q;

endmodule

// File: rtl/sargantana_itag_store.sv
// Instruction-cache tag store: N_WAY way arrays, a flush/init sweep FSM and tag compare.
module sargantana_itag_store
  import sargantana_icache_pkg::*;
#(
  parameter int N_WAY = ICACHE_N_WAY,
  parameter int DEPTH = ICACHE_DEPTH,
  parameter int TAG_W = TAG_WIDHT
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [N_WAY-1:0]             req_i,
  input  logic                         we_i,
  input  logic                         vbit_i,
  input  logic [TAG_W-1:0]             data_i,
  input  logic [$clog2(DEPTH)-1:0]     addr_i,
  input  logic [TAG_W-1:0]             cmp_tag_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  output logic [N_WAY-1:0][TAG_W-1:0]  tag_way_o,
  output logic [N_WAY-1:0]             vbit_o,
  output logic                         rvalid_o,
  output logic [N_WAY-1:0]             hit_way_o,
  output logic                         hit_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_SET = ADDR_W'(DEPTH - 1);

  itag_store_state_t state_d, state_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              rvalid_d, rvalid_q;
  logic [N_WAY-1:0]  req_d, req_q;
  logic [TAG_W-1:0]  cmp_d, cmp_q;

  logic                        accept;
  logic                        sweeping;
  logic [N_WAY-1:0]            way_we;
  logic [N_WAY-1:0]            way_re;
  logic [N_WAY-1:0][TAG_W-1:0] rd_tag;
  logic [N_WAY-1:0]            rd_vbit;

  assign ready_o  = (state_q == IDLE);
  assign sweeping = (state_q == SWEEP);
  // A flush in the same cycle as a request takes priority and drops the request.
  assign accept   = ready_o & (|req_i) & ~flush_i;
  assign way_we   = {N_WAY{accept & we_i}} & req_i;
  assign way_re   = {N_WAY{accept & ~we_i}} & req_i;

  // Next-state logic: IDLE waits for a flush, SWEEP walks every set once and returns.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST_SET) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  // Read sideband: remember which ways were asked for and the compare tag for the result cycle.
  always_comb begin
    rvalid_d = accept & ~we_i;
    req_d    = req_q;
    cmp_d    = cmp_q;
    if (rvalid_d) begin
      req_d = req_i;
      cmp_d = cmp_tag_i;
    end
  end

  // Control flops; reset lands in SWEEP so the valid bits are scrubbed before first use.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= SWEEP;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      req_q    <= '0;
      cmp_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      req_q    <= req_d;
      cmp_q    <= cmp_d;
    end
  end

  for (genvar w = 0; w < N_WAY; w++) begin : g_way
    sargantana_itag_way_array #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
    ) u_way (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .we_i       (way_we[w]),
      .re_i       (way_re[w]),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .vbit_i     (vbit_i),
      .clr_i      (sweeping),
      .clr_addr_i (cnt_q),
      .tag_o      (rd_tag[w]),
      .vbit_o     (rd_vbit[w])
    );
  end

  // Result masking and compare: only requested ways on the result cycle report valid or hit.
  always_comb begin
    vbit_o    = '0;
    hit_way_o = '0;
    for (int w = 0; w < N_WAY; w++) begin
      vbit_o[w]    = rvalid_q & req_q[w] & rd_vbit[w];
      hit_way_o[w] = rvalid_q & req_q[w] & rd_vbit[w] & (rd_tag[w] == cmp_q);
    end
  end

  assign tag_way_o = rd_tag;
  assign rvalid_o  = rvalid_q;
  assign hit_o     = |hit_way_o;

endmodule
